// File: rtl/jk_pkg.sv
// Shared types for the JK excitation driver: FSM encoding, mode values and
// the q/target/mode -> {J,K} excitation function.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam logic MODE_HOLD   = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  typedef struct packed {
    logic j;
    logic k;
  } jk_t;

  // The don't-care input of each transition resolves to the mode bit.
  function automatic jk_t excite(input logic q, input logic tgt, input logic mode);
    jk_t r;
    if (!q) begin
      r.j = tgt;
      r.k = mode;
    end else begin
      r.j = mode;
      r.k = ~tgt;
    end
    return r;
  endfunction

endpackage

// File: rtl/jk_tgt_fifo.sv
// DEPTH x 1-bit synchronous target FIFO with full/empty flags.
module jk_tgt_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic head_c_o,
  output logic full_c_o,
  output logic empty_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_c_o) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_i && !empty_c_o) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  assign head_c_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_c_o = (wr_ptr_q == rd_ptr_q);
  assign full_c_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/jk_excite_driver.sv
// Drives J/K into an external JK flop for each queued target bit, then
// checks the flop's q and keeps completion/mismatch statistics.
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             mode,
  input  logic             clr_stats,
  input  logic             q_in,
  output logic             J,
  output logic             K,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] done_cnt
);

  logic   fifo_head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop_c;
  jk_t    jk_c;

  state_e           state_q, state_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             tgt_q, tgt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  jk_tgt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push_i    (tgt_valid),
    .din_i     (tgt_bit),
    .pop_i     (pop_c),
    .head_c_o  (fifo_head),
    .full_c_o  (fifo_full),
    .empty_c_o (fifo_empty)
  );

  assign jk_c = excite(q_in, fifo_head, mode);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      j_q        <= 1'b0;
      k_q        <= 1'b0;
      tgt_q      <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      k_q        <= k_d;
      tgt_q      <= tgt_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // J/K default to zero so they are only ever non-zero during DRIVE.
  always_comb begin
    state_d    = state_q;
    j_d        = 1'b0;
    k_d        = 1'b0;
    tgt_d      = tgt_q;
    pop_c      = 1'b0;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    done_cnt_d = done_cnt_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          j_d     = jk_c.j;
          k_d     = jk_c.k;
          tgt_d   = fifo_head;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        done_cnt_d = done_cnt_q + CNT_W'(1);
        if (q_in != tgt_q) begin
          err_d = 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          j_d     = jk_c.j;
          k_d     = jk_c.k;
          tgt_d   = fifo_head;
          state_d = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A clear on the same edge as a CHECK update takes precedence.
    if (clr_stats) begin
      err_d      = 1'b0;
      err_cnt_d  = '0;
      done_cnt_d = '0;
    end
  end

  assign J         = j_q;
  assign K         = k_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign done_cnt  = done_cnt_q;
  assign tgt_ready = !fifo_full;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: a behavioural JK flop closes the loop, table
// vectors feed a scoreboard checked at each completed target.
module tb_jk_excite_driver;
  import jk_pkg::*;

  typedef struct packed {
    logic mode;
    logic tgt;
    logic ej;
    logic ek;
    logic eq;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       tgt_valid;
  logic       tgt_bit;
  logic       tgt_ready;
  logic       mode;
  logic       clr_stats;
  logic       q_in;
  logic       J;
  logic       K;
  logic       busy;
  logic       err;
  logic [7:0] err_cnt;
  logic [7:0] done_cnt;

  logic       tgt_valid2;
  logic       tgt_bit2;
  logic       tgt_ready2;
  logic       J2;
  logic       K2;
  logic       busy2;
  logic       err2;
  logic [1:0] err_cnt2;
  logic [1:0] done_cnt2;

  logic       fq;
  logic       stuck;

  int         n_tests;
  int         n_fail;
  vec_t       vt [25];
  vec_t       sbq [$];
  logic       mon_en;
  logic [1:0] jk_h1;
  logic [1:0] jk_h2;
  logic       q_h1;
  logic [7:0] done_prev;
  logic       saw_stall;

  jk_excite_driver #(.DEPTH(4), .CNT_W(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_bit   (tgt_bit),
    .tgt_ready (tgt_ready),
    .mode      (mode),
    .clr_stats (clr_stats),
    .q_in      (q_in),
    .J         (J),
    .K         (K),
    .busy      (busy),
    .err       (err),
    .err_cnt   (err_cnt),
    .done_cnt  (done_cnt)
  );

  // Narrow-counter instance with its flop disconnected (q stuck at 0).
  jk_excite_driver #(.DEPTH(4), .CNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid2),
    .tgt_bit   (tgt_bit2),
    .tgt_ready (tgt_ready2),
    .mode      (mode),
    .clr_stats (clr_stats),
    .q_in      (1'b0),
    .J         (J2),
    .K         (K2),
    .busy      (busy2),
    .err       (err2),
    .err_cnt   (err_cnt2),
    .done_cnt  (done_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) fq <= 1'b0;
    else begin
      case ({J, K})
        2'b10:   fq <= 1'b1;
        2'b01:   fq <= 1'b0;
        2'b11:   fq <= ~fq;
        default: fq <= fq;
      endcase
    end
  end

  assign q_in = stuck ? 1'b0 : fq;

  function automatic vec_t mk(input logic m, input logic t, input logic j,
                              input logic k, input logic q);
    vec_t v;
    v.mode = m; v.tgt = t; v.ej = j; v.ek = k; v.eq = q;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // A done_cnt change means a target just finished: its DRIVE sample is two
  // ticks back and its CHECK sample (J=K=0, updated q) one tick back.
  task automatic mon_step();
    vec_t e;
    if (mon_en && rst && (done_cnt != done_prev)) begin
      if (sbq.size() == 0) begin
        chk("completion_has_target", 32'(sbq.size()), 32'(1));
      end else begin
        e = sbq.pop_front();
        chk("target_jk_q", 32'({jk_h2, jk_h1, q_h1}), 32'({e.ej, e.ek, 2'b00, e.eq}));
      end
    end
    if (tgt_valid && !tgt_ready) saw_stall = 1'b1;
    jk_h2     = jk_h1;
    jk_h1     = {J, K};
    q_h1      = q_in;
    done_prev = done_cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon_step();
  endtask

  task automatic push_vec(input int idx);
    int t;
    mode      = vt[idx].mode;
    tgt_bit   = vt[idx].tgt;
    tgt_valid = 1'b1;
    t = 0;
    while (!tgt_ready && t < 100) begin
      tick();
      t++;
    end
    if (!tgt_ready) begin
      chk("push_ready_timeout", 32'(tgt_ready), 32'(1));
    end else begin
      sbq.push_back(vt[idx]);
      tick();
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || busy) && t < 300) begin
      tick();
      t++;
    end
    chk("drain", 32'({sbq.size() != 0, busy}), 32'(0));
  endtask

  task automatic do_reset();
    tgt_valid  = 1'b0;
    tgt_valid2 = 1'b0;
    clr_stats  = 1'b0;
    rst        = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    int t;
    n_tests = 0; n_fail = 0;
    rst = 1'b0; tgt_valid = 1'b0; tgt_bit = 1'b0; mode = MODE_HOLD;
    clr_stats = 1'b0; tgt_valid2 = 1'b0; tgt_bit2 = 1'b0; stuck = 1'b0;
    mon_en = 1'b1; jk_h1 = 2'b00; jk_h2 = 2'b00; q_h1 = 1'b0;
    done_prev = 8'd0; saw_stall = 1'b0;

    // {mode, target, J, K, q after update}
    vt[0]  = mk(MODE_HOLD,   1, 1, 0, 1);
    vt[1]  = mk(MODE_HOLD,   0, 0, 1, 0);
    vt[2]  = mk(MODE_HOLD,   0, 0, 0, 0);
    vt[3]  = mk(MODE_HOLD,   1, 1, 0, 1);
    vt[4]  = mk(MODE_TOGGLE, 1, 1, 1, 1);
    vt[5]  = mk(MODE_TOGGLE, 0, 1, 1, 0);
    vt[6]  = mk(MODE_TOGGLE, 0, 0, 1, 0);
    vt[7]  = mk(MODE_HOLD,   1, 1, 0, 1);
    vt[8]  = mk(MODE_HOLD,   1, 0, 0, 1);
    vt[9]  = mk(MODE_HOLD,   0, 0, 1, 0);
    vt[10] = mk(MODE_HOLD,   1, 1, 0, 1);
    vt[11] = mk(MODE_HOLD,   0, 0, 1, 0);
    vt[12] = mk(MODE_HOLD,   0, 0, 0, 0);
    vt[13] = mk(MODE_HOLD,   1, 1, 0, 1);
    vt[14] = mk(MODE_HOLD,   0, 0, 1, 0);
    vt[15] = mk(MODE_HOLD,   1, 1, 0, 0);
    vt[16] = mk(MODE_HOLD,   1, 1, 0, 0);
    vt[17] = mk(MODE_HOLD,   1, 1, 0, 0);
    vt[18] = mk(MODE_HOLD,   1, 1, 0, 1);
    vt[19] = mk(MODE_HOLD,   0, 0, 1, 0);
    vt[20] = mk(MODE_HOLD,   1, 1, 0, 1);
    vt[21] = mk(MODE_HOLD,   0, 0, 1, 0);
    vt[22] = mk(MODE_HOLD,   1, 1, 0, 1);
    vt[23] = mk(MODE_HOLD,   0, 0, 1, 0);
    vt[24] = mk(MODE_HOLD,   1, 1, 0, 1);

    // reset state
    tick();
    tick();
    chk("rst_jk", 32'({J, K}), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_cnts", 32'({err_cnt, done_cnt}), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    rst = 1'b1;
    tick();
    chk("ready_after_rst", 32'(tgt_ready), 32'(1));

    // hold-mode sequence
    for (int i = 0; i <= 3; i++) push_vec(i);
    tgt_valid = 1'b0;
    wait_drain();
    chk("s1_done", 32'(done_cnt), 32'(4));
    chk("s1_err", 32'({err, err_cnt}), 32'(0));

    // toggle-mode sequence
    do_reset();
    for (int i = 4; i <= 6; i++) push_vec(i);
    tgt_valid = 1'b0;
    wait_drain();
    chk("s2_done", 32'(done_cnt), 32'(3));
    chk("s2_err", 32'({err, err_cnt}), 32'(0));

    // back-to-back burst fills the FIFO and stalls the producer
    do_reset();
    saw_stall = 1'b0;
    for (int i = 7; i <= 14; i++) push_vec(i);
    tgt_valid = 1'b0;
    wait_drain();
    chk("s3_stall_seen", 32'(saw_stall), 32'(1));
    chk("s3_done", 32'(done_cnt), 32'(8));
    chk("s3_err", 32'(err), 32'(0));

    // flop disconnected: every target mismatches
    do_reset();
    stuck = 1'b1;
    for (int i = 15; i <= 17; i++) push_vec(i);
    tgt_valid = 1'b0;
    wait_drain();
    chk("s4_err", 32'(err), 32'(1));
    chk("s4_err_cnt", 32'(err_cnt), 32'(3));
    chk("s4_done", 32'(done_cnt), 32'(3));

    // clr_stats coinciding with a mismatching CHECK
    mon_en = 1'b0;
    mode = MODE_HOLD; tgt_bit = 1'b1; tgt_valid = 1'b1;
    tick();
    tgt_valid = 1'b0;
    tick();
    chk("clr_drive_jk", 32'({J, K}), 32'(2'b10));
    tick();
    chk("clr_check_busy", 32'({busy, J, K}), 32'(3'b100));
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_wins", 32'({err, err_cnt, done_cnt}), 32'(0));
    chk("clr_idle", 32'(busy), 32'(0));
    stuck = 1'b0;
    mon_en = 1'b1;

    // CNT_W=2: err_cnt saturates, done_cnt wraps
    do_reset();
    mode = MODE_HOLD;
    tgt_bit2 = 1'b1; tgt_valid2 = 1'b1;
    n = 0; t = 0;
    while (n < 5 && t < 200) begin
      if (tgt_ready2) n++;
      tick();
      t++;
    end
    tgt_valid2 = 1'b0;
    t = 0;
    while (busy2 && t < 200) begin
      tick();
      t++;
    end
    chk("w2_idle", 32'({n == 5, busy2}), 32'(2'b10));
    chk("w2_err_cnt_sat", 32'(err_cnt2), 32'(3));
    chk("w2_done_wrap", 32'(done_cnt2), 32'(1));
    chk("w2_err", 32'(err2), 32'(1));

    // reset while DRIVE is active with three targets queued
    do_reset();
    for (int i = 18; i <= 23; i++) push_vec(i);
    tgt_valid = 1'b0;
    chk("pre_rst_done", 32'(done_cnt), 32'(2));
    chk("pre_rst_jk", 32'({J, K}), 32'(2'b10));
    rst = 1'b0;
    #1;
    chk("mid_rst_jk", 32'({J, K}), 32'(0));
    chk("mid_rst_busy", 32'({busy, tgt_ready}), 32'(2'b01));
    chk("mid_rst_cnts", 32'({err, err_cnt, done_cnt}), 32'(0));
    sbq.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
    push_vec(24);
    tgt_valid = 1'b0;
    wait_drain();
    chk("post_rst_done", 32'(done_cnt), 32'(1));
    chk("post_rst_err", 32'(err), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
